centroid_div_sched: RTL and testbench

- Sequences one shared 28/20 sequential divider to compute the frame centroid: x = m10/m00, then y = m01/m00.
- Sits between the moment accumulators (m00/m10/m01 counters cleared at end of frame) and the centroid latches that feed the inside-circle overlay.
- Snapshots the moments at end of frame, issues the two divides back-to-back, guards against empty masks and a hung divider, and publishes x/y with a valid pulse.

---
 rtl/centroid_div_sched_pkg.sv | 28 ++
 rtl/centroid_clamp.sv | 15 +
 rtl/centroid_div_sched.sv | 150 +++++++++++++++
 tb/tb_centroid_div_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/centroid_div_sched_pkg.sv
// rtl/centroid_div_sched_pkg.sv - shared types, widths and clamp helper for the centroid divide scheduler
package centroid_div_sched_pkg;

    localparam int MOM_W   = 28;
    localparam int COORD_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE_X = 3'd1,
        ST_WAIT_X  = 3'd2,
        ST_ISSUE_Y = 3'd3,
        ST_WAIT_Y  = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Saturate a divider quotient to limit-1 and return it as a coordinate.
    function automatic logic [COORD_W-1:0] clamp_coord(
        input logic [MOM_W-1:0] q,
        input int unsigned      limit
    );
        logic [MOM_W-1:0] max_q;
        max_q = MOM_W'(limit - 1);
        if (q > max_q)
            return max_q[COORD_W-1:0];
        return q[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/centroid_clamp.sv
// rtl/centroid_clamp.sv - combinational saturation of a quotient to a LIMIT-1 coordinate
//   quotient : divider result (MOM_W bits)
//   coord    : min(quotient, LIMIT-1), COORD_W bits
module centroid_clamp
    import centroid_div_sched_pkg::*;
#(
    parameter int unsigned LIMIT = 720
) (
    input  logic [MOM_W-1:0]   quotient,
    output logic [COORD_W-1:0] coord
);

    assign coord = clamp_coord(quotient, LIMIT);

endmodule

// File: rtl/centroid_div_sched.sv
// rtl/centroid_div_sched.sv - sequences one shared divider to compute the frame centroid x=m10/m00, y=m01/m00
//   clk, rst (async, active low)
//   eof, m00, m10, m01          : end-of-frame pulse and moment accumulators
//   div_start, div_dividend,
//   div_divisor, div_quotient,
//   div_qv                       : handshake to the external shared divider
//   x, y, centroid_valid         : published centroid and its update pulse
//   busy, empty_frame, overrun,
//   timeout                      : status
module centroid_div_sched
    import centroid_div_sched_pkg::*;
#(
    parameter int unsigned IMG_W       = 720,
    parameter int unsigned IMG_H       = 576,
    parameter int unsigned DIV_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               eof,
    input  logic [MOM_W-1:0]   m00,
    input  logic [MOM_W-1:0]   m10,
    input  logic [MOM_W-1:0]   m01,
    output logic               div_start,
    output logic [MOM_W-1:0]   div_dividend,
    output logic [MOM_W-1:0]   div_divisor,
    input  logic [MOM_W-1:0]   div_quotient,
    input  logic               div_qv,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               centroid_valid,
    output logic               busy,
    output logic               empty_frame,
    output logic               overrun,
    output logic               timeout
);

    localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   wait_cnt;
    logic [MOM_W-1:0]   snap_m01;
    logic [COORD_W-1:0] x_cand;
    logic [COORD_W-1:0] x_clamped, y_clamped;
    logic               capture;
    logic               in_wait;
    logic               expire;

    // eof is only honoured when no divide is in flight.
    assign capture = eof && (state == ST_IDLE || state == ST_DONE);
    assign in_wait = (state == ST_WAIT_X) || (state == ST_WAIT_Y);
    // wait_cnt is 0 in the first WAIT cycle, so it reads DIV_TIMEOUT-2 in the
    // cycle DIV_TIMEOUT-1 after div_start; aborting on that edge makes the
    // timeout pulse land exactly DIV_TIMEOUT cycles after div_start.
    assign expire  = (wait_cnt == CNT_W'(DIV_TIMEOUT - 2));

    centroid_clamp #(.LIMIT(IMG_W)) u_clamp_x (
        .quotient (div_quotient),
        .coord    (x_clamped)
    );

    centroid_clamp #(.LIMIT(IMG_H)) u_clamp_y (
        .quotient (div_quotient),
        .coord    (y_clamped)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (capture && (m00 != '0))
                    state_n = ST_ISSUE_X;
                else
                    state_n = ST_IDLE;
            end
            ST_ISSUE_X: state_n = ST_WAIT_X;
            ST_WAIT_X: begin
                if (div_qv)
                    state_n = ST_ISSUE_Y;
                else if (expire)
                    state_n = ST_IDLE;
            end
            ST_ISSUE_Y: state_n = ST_WAIT_Y;
            ST_WAIT_Y: begin
                if (div_qv)
                    state_n = ST_DONE;
                else if (expire)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        div_start      = (state == ST_ISSUE_X) || (state == ST_ISSUE_Y);
        busy           = (state != ST_IDLE);
        centroid_valid = (state == ST_DONE);
    end

    // The operand registers double as the m00/m10 snapshots: they are loaded
    // at capture and stay put until the next capture, except that the dividend
    // switches to the m01 snapshot once the x quotient has been taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_dividend <= '0;
            div_divisor  <= '0;
            snap_m01     <= '0;
            wait_cnt     <= '0;
            x_cand       <= '0;
            x            <= '0;
            y            <= '0;
            empty_frame  <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            empty_frame <= capture && (m00 == '0);
            overrun     <= eof && !capture;
            timeout     <= in_wait && !div_qv && expire;

            if (capture) begin
                div_dividend <= m10;
                div_divisor  <= m00;
                snap_m01     <= m01;
            end

            if (div_start)
                wait_cnt <= '0;
            else if (in_wait)
                wait_cnt <= wait_cnt + 1'b1;

            if (state == ST_WAIT_X && div_qv) begin
                x_cand       <= x_clamped;
                div_dividend <= snap_m01;
            end

            // x and y are written together only when the y divide completes.
            if (state == ST_WAIT_Y && div_qv) begin
                x <= x_cand;
                y <= y_clamped;
            end
        end
    end

endmodule

// File: tb/tb_centroid_div_sched.sv
// tb/tb_centroid_div_sched.sv - directed self-checking bench for centroid_div_sched
module tb_centroid_div_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        eof = 1'b0;
    logic [27:0] m00 = '0;
    logic [27:0] m10 = '0;
    logic [27:0] m01 = '0;
    logic        div_start;
    logic [27:0] div_dividend;
    logic [27:0] div_divisor;
    logic [27:0] div_quotient = '0;
    logic        div_qv = 1'b0;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        centroid_valid;
    logic        busy;
    logic        empty_frame;
    logic        overrun;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    centroid_div_sched #(
        .IMG_W       (720),
        .IMG_H       (576),
        .DIV_TIMEOUT (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .eof            (eof),
        .m00            (m00),
        .m10            (m10),
        .m01            (m01),
        .div_start      (div_start),
        .div_dividend   (div_dividend),
        .div_divisor    (div_divisor),
        .div_quotient   (div_quotient),
        .div_qv         (div_qv),
        .x              (x),
        .y              (y),
        .centroid_valid (centroid_valid),
        .busy           (busy),
        .empty_frame    (empty_frame),
        .overrun        (overrun),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse eof for one cycle with the given moments; returns in the cycle after eof.
    task automatic send_eof(input logic [27:0] a00, input logic [27:0] a10, input logic [27:0] a01);
        eof = 1'b1; m00 = a00; m10 = a10; m01 = a01;
        @(negedge clk);
        eof = 1'b0;
    endtask

    // Wait (bounded) for div_start, check operands, return the start cycle.
    task automatic wait_start(input string tag, input logic [27:0] exp_dd,
                              input logic [27:0] exp_ds, output int sc);
        int k;
        k = 0;
        while (div_start !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_start_seen"}, div_start, 1);
        sc = cyc;
        chk({tag, "_dividend"}, div_dividend, exp_dd);
        chk({tag, "_divisor"}, div_divisor, exp_ds);
    endtask

    // Return quotient q in the cycle gap cycles after the current one.
    task automatic respond(input logic [27:0] q, input int gap);
        repeat (gap) @(negedge clk);
        div_quotient = q;
        div_qv = 1'b1;
        @(negedge clk);
        div_qv = 1'b0;
    endtask

    initial begin
        int s1, s2, cnt, k, tcyc;

        // Reset state
        #1;
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_dividend", div_dividend, 0);
        chk("rst_valid", centroid_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Basic frame: 400/4 = 100, 200/4 = 50, starts 32 cycles apart
        send_eof(28'd4, 28'd400, 28'd200);
        wait_start("basic_x", 28'd400, 28'd4, s1);
        respond(28'd100, 31);
        wait_start("basic_y", 28'd200, 28'd4, s2);
        chk("basic_start_gap", s2 - s1, 32);
        respond(28'd50, 31);
        chk("basic_valid", centroid_valid, 1);
        chk("basic_x", x, 100);
        chk("basic_y", y, 50);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (centroid_valid === 1'b1) cnt++;
        end
        chk("basic_valid_once", cnt, 0);
        chk("basic_idle", busy, 0);

        // Empty mask
        send_eof(28'd0, 28'd0, 28'd0);
        chk("empty_pulse", empty_frame, 1);
        chk("empty_busy", busy, 0);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (div_start === 1'b1 || centroid_valid === 1'b1) cnt++;
        end
        chk("empty_no_start", cnt, 0);
        chk("empty_x_kept", x, 100);
        chk("empty_y_kept", y, 50);

        // Overrun: second eof 10 cycles after the first, during WAIT_X
        send_eof(28'd2, 28'd300, 28'd100);
        wait_start("ovr_x", 28'd300, 28'd2, s1);
        repeat (9) @(negedge clk);
        send_eof(28'd1, 28'd7, 28'd7);
        chk("ovr_pulse", overrun, 1);
        chk("ovr_busy", busy, 1);
        respond(28'd150, 20);
        wait_start("ovr_y", 28'd100, 28'd2, s2);
        respond(28'd50, 3);
        chk("ovr_valid", centroid_valid, 1);
        chk("ovr_x", x, 150);
        chk("ovr_y", y, 50);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (centroid_valid === 1'b1) cnt++;
        end
        chk("ovr_valid_once", cnt, 0);

        // Divider never answers: timeout 64 cycles after div_start
        send_eof(28'd3, 28'd30, 28'd30);
        wait_start("tmo_x", 28'd30, 28'd3, s1);
        k = 0;
        tcyc = -1;
        while (k < 100 && tcyc < 0) begin
            @(negedge clk);
            k++;
            if (timeout === 1'b1) tcyc = cyc;
        end
        chk("tmo_delay", tcyc - s1, 64);
        chk("tmo_busy", busy, 0);
        chk("tmo_x_kept", x, 150);
        chk("tmo_y_kept", y, 50);
        @(negedge clk);
        chk("tmo_pulse_width", timeout, 0);

        // Next frame after timeout, with both coordinates saturating
        send_eof(28'd1, 28'd5000, 28'd900);
        wait_start("clamp_x", 28'd5000, 28'd1, s1);
        respond(28'd5000, 4);
        wait_start("clamp_y", 28'd900, 28'd1, s2);
        respond(28'd900, 4);
        chk("clamp_valid", centroid_valid, 1);
        chk("clamp_x", x, 719);
        chk("clamp_y", y, 575);
        @(negedge clk);

        // Reset during WAIT_Y, then a stray quotient
        send_eof(28'd2, 28'd20, 28'd10);
        wait_start("rst_seq_x", 28'd20, 28'd2, s1);
        respond(28'd10, 2);
        wait_start("rst_seq_y", 28'd10, 28'd2, s2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async_rst_x", x, 0);
        chk("async_rst_y", y, 0);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        div_quotient = 28'd5;
        div_qv = 1'b1;
        @(negedge clk);
        div_qv = 1'b0;
        cnt = 0;
        repeat (5) begin
            if (centroid_valid === 1'b1 || busy === 1'b1) cnt++;
            @(negedge clk);
        end
        chk("stray_qv_ignored", cnt, 0);
        chk("stray_x", x, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
